// File: rtl/rob.sv
// Reorder buffer: circular in-order retirement queue fed by dispatch and the CDB.
package ooo_types;
   localparam int unsigned OOO_ROB_DEPTH = 6;
   localparam int unsigned TAG_W         = $clog2(OOO_ROB_DEPTH + 1);

   typedef logic [TAG_W-1:0] tag_t;
   typedef logic [31:0]      rv32i_word;
   typedef enum logic [1:0] {OP_REG = 2'd0, OP_ST = 2'd1, OP_BR = 2'd2} op_type_t;

   // Tag 0 means "no free entry"; busy/vals are indexed by tag-1.
   typedef struct packed {
      tag_t                               tag;
      logic [OOO_ROB_DEPTH-1:0]           busy;
      rv32i_word [OOO_ROB_DEPTH-1:0]      vals;
   } rob_out_t;
endpackage

module rob
   import ooo_types::*;
#(
   parameter int unsigned ROB_DEPTH = OOO_ROB_DEPTH
) (
   input  logic      clk,
   input  logic      rst,
   input  logic      alloc_valid,
   input  op_type_t  alloc_op,
   input  logic [4:0] alloc_rd,
   input  logic      cdb_valid,
   input  tag_t      cdb_tag,
   input  rv32i_word cdb_val,
   input  logic      cdb_mispredict,
   input  logic      st_ready,
   output rob_out_t  rob_out,
   output logic      commit_valid,
   output op_type_t  commit_op,
   output logic [4:0] commit_rd,
   output rv32i_word commit_val,
   output tag_t      commit_tag,
   output logic      flush,
   output rv32i_word flush_pc
);

   localparam int unsigned IDX_W = (ROB_DEPTH > 1) ? $clog2(ROB_DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(ROB_DEPTH + 1);

   logic       r_valid [ROB_DEPTH];
   logic       r_done  [ROB_DEPTH];
   op_type_t   r_op    [ROB_DEPTH];
   logic [4:0] r_rd    [ROB_DEPTH];
   rv32i_word  r_val   [ROB_DEPTH];
   logic       r_mis   [ROB_DEPTH];

   logic [IDX_W-1:0] r_head;
   logic [IDX_W-1:0] r_tail;
   logic [CNT_W-1:0] r_count;

   logic             w_full;
   tag_t             w_free_tag;
   logic             w_alloc;
   logic             w_cdb_in_range;
   logic [IDX_W-1:0] w_cdb_idx;
   logic             w_cdb_hit;

   function automatic logic [IDX_W-1:0] f_next(input logic [IDX_W-1:0] p);
      return (p == IDX_W'(ROB_DEPTH - 1)) ? '0 : p + IDX_W'(1);
   endfunction

   // Free-tag, allocation and CDB-match decode (full status from registered count).
   always_comb begin
      w_full         = (r_count == CNT_W'(ROB_DEPTH));
      w_free_tag     = w_full ? '0 : TAG_W'(r_tail) + TAG_W'(1);
      w_alloc        = alloc_valid && (w_free_tag != '0);
      w_cdb_in_range = cdb_valid && (cdb_tag != '0) && (cdb_tag <= TAG_W'(ROB_DEPTH));
      w_cdb_idx      = w_cdb_in_range ? IDX_W'(cdb_tag - TAG_W'(1)) : '0;
      w_cdb_hit      = w_cdb_in_range && r_valid[w_cdb_idx] && !r_done[w_cdb_idx];
   end

   // Status view for dispatch and reservation stations.
   always_comb begin
      rob_out     = '0;
      rob_out.tag = w_free_tag;
      for (int i = 0; i < ROB_DEPTH; i++) begin
         rob_out.busy[i] = ~(r_valid[i] & r_done[i]);
         rob_out.vals[i] = r_val[i];
      end
   end

   // Head-entry retirement and mispredict flush.
   always_comb begin
      commit_op    = r_op[r_head];
      commit_rd    = r_rd[r_head];
      commit_val   = r_val[r_head];
      commit_tag   = TAG_W'(r_head) + TAG_W'(1);
      commit_valid = (r_count != '0) && r_valid[r_head] && r_done[r_head] &&
                     ((r_op[r_head] != OP_ST) || st_ready);
      flush        = commit_valid && (r_op[r_head] == OP_BR) && r_mis[r_head];
      flush_pc     = flush ? r_val[r_head] : '0;
   end

   // Entry array and pointer updates; a flush overrides alloc and CDB.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < ROB_DEPTH; i++) begin
            r_valid[i] <= 1'b0;
            r_done[i]  <= 1'b0;
            r_op[i]    <= OP_REG;
            r_rd[i]    <= '0;
            r_val[i]   <= '0;
            r_mis[i]   <= 1'b0;
         end
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else if (flush) begin
         for (int i = 0; i < ROB_DEPTH; i++) begin
            r_valid[i] <= 1'b0;
            r_done[i]  <= 1'b0;
            r_op[i]    <= OP_REG;
            r_rd[i]    <= '0;
            r_val[i]   <= '0;
            r_mis[i]   <= 1'b0;
         end
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         if (w_cdb_hit) begin
            r_done[w_cdb_idx] <= 1'b1;
            r_val[w_cdb_idx]  <= cdb_val;
            r_mis[w_cdb_idx]  <= cdb_mispredict;
         end
         if (commit_valid) begin
            r_valid[r_head] <= 1'b0;
            r_done[r_head]  <= 1'b0;
            r_op[r_head]    <= OP_REG;
            r_rd[r_head]    <= '0;
            r_val[r_head]   <= '0;
            r_mis[r_head]   <= 1'b0;
            r_head          <= f_next(r_head);
         end
         if (w_alloc) begin
            r_valid[r_tail] <= 1'b1;
            r_done[r_tail]  <= 1'b0;
            r_op[r_tail]    <= alloc_op;
            r_rd[r_tail]    <= alloc_rd;
            r_val[r_tail]   <= '0;
            r_mis[r_tail]   <= 1'b0;
            r_tail          <= f_next(r_tail);
         end
         case ({w_alloc, commit_valid})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: tb/tb_rob.sv
// Self-checking bench for rob: directed scenarios plus randomized traffic against a queue model.
module tb_rob;
   import ooo_types::*;

   localparam int unsigned D = OOO_ROB_DEPTH;

   logic       clk;
   logic       rst;
   logic       alloc_valid;
   op_type_t   alloc_op;
   logic [4:0] alloc_rd;
   logic       cdb_valid;
   tag_t       cdb_tag;
   rv32i_word  cdb_val;
   logic       cdb_mispredict;
   logic       st_ready;
   rob_out_t   rob_out;
   logic       commit_valid;
   op_type_t   commit_op;
   logic [4:0] commit_rd;
   rv32i_word  commit_val;
   tag_t       commit_tag;
   logic       flush;
   rv32i_word  flush_pc;

   int n_checks = 0;
   int n_errors = 0;

   rob #(.ROB_DEPTH(D)) dut (
      .clk(clk), .rst(rst),
      .alloc_valid(alloc_valid), .alloc_op(alloc_op), .alloc_rd(alloc_rd),
      .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_val(cdb_val),
      .cdb_mispredict(cdb_mispredict), .st_ready(st_ready),
      .rob_out(rob_out),
      .commit_valid(commit_valid), .commit_op(commit_op), .commit_rd(commit_rd),
      .commit_val(commit_val), .commit_tag(commit_tag),
      .flush(flush), .flush_pc(flush_pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model entry: one in-flight instruction in program order.
   typedef struct {
      tag_t       tag;
      op_type_t   op;
      logic [4:0] rd;
      bit         done;
      rv32i_word  val;
      bit         mis;
   } m_ent_t;

   task automatic idle_inputs();
      alloc_valid = 1'b0; alloc_op = OP_REG; alloc_rd = '0;
      cdb_valid = 1'b0; cdb_tag = '0; cdb_val = '0; cdb_mispredict = 1'b0;
      st_ready = 1'b1;
   endtask

   // Advance one clock; inputs are applied and outputs sampled 1ns after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      idle_inputs();
      @(posedge clk);
      #2 rst = 1'b0;
      #10 rst = 1'b1;
      step();
   endtask

   task automatic test_reset();
      do_reset();
      n_checks++; if (rob_out.tag !== tag_t'(1)) begin n_errors++; $display("FAIL reset_tag got %0d exp 1", rob_out.tag); end
      n_checks++; if (rob_out.busy !== '1) begin n_errors++; $display("FAIL reset_busy got %b exp all ones", rob_out.busy); end
      n_checks++; if (rob_out.vals !== '0) begin n_errors++; $display("FAIL reset_vals got %h exp 0", rob_out.vals); end
      n_checks++; if (commit_valid !== 1'b0 || flush !== 1'b0 || flush_pc !== '0) begin
         n_errors++; $display("FAIL reset_commit got cv=%b fl=%b pc=%h exp 0 0 0", commit_valid, flush, flush_pc); end
      // Two entries in flight, one completed, then an asynchronous reset mid-cycle.
      alloc_valid = 1'b1; alloc_op = OP_REG; alloc_rd = 5'd3;
      step(); step();
      alloc_valid = 1'b0; cdb_valid = 1'b1; cdb_tag = tag_t'(1); cdb_val = 32'h1234;
      step();
      cdb_valid = 1'b0;
      #2 rst = 1'b0;
      #1;
      n_checks++; if (rob_out.tag !== tag_t'(1) || rob_out.busy !== '1 || rob_out.vals !== '0 || commit_valid !== 1'b0) begin
         n_errors++; $display("FAIL async_reset got tag=%0d busy=%b cv=%b exp tag=1 busy=all1 cv=0", rob_out.tag, rob_out.busy, commit_valid); end
      #4 rst = 1'b1;
      step();
   endtask

   task automatic test_fill();
      do_reset();
      for (int i = 1; i <= int'(D); i++) begin
         alloc_valid = 1'b1; alloc_op = OP_REG; alloc_rd = 5'(i);
         #1;
         n_checks++; if (rob_out.tag !== tag_t'(i)) begin n_errors++; $display("FAIL fill_tag%0d got %0d exp %0d", i, rob_out.tag, i); end
         step();
      end
      n_checks++; if (rob_out.tag !== tag_t'(0)) begin n_errors++; $display("FAIL full_tag got %0d exp 0", rob_out.tag); end
      alloc_rd = 5'd7;
      step();
      alloc_valid = 1'b0;
      #1;
      n_checks++; if (rob_out.tag !== tag_t'(0) || commit_valid !== 1'b0 || rob_out.busy !== '1) begin
         n_errors++; $display("FAIL full_ignore got tag=%0d cv=%b busy=%b exp 0 0 all1", rob_out.tag, commit_valid, rob_out.busy); end
      n_checks++; if (commit_tag !== tag_t'(1) || commit_rd !== 5'd1) begin
         n_errors++; $display("FAIL full_head got tag=%0d rd=%0d exp 1 1", commit_tag, commit_rd); end
   endtask

   task automatic test_single();
      do_reset();
      alloc_valid = 1'b1; alloc_op = OP_REG; alloc_rd = 5'd5;
      step();
      alloc_valid = 1'b0;
      cdb_valid = 1'b1; cdb_tag = tag_t'(1); cdb_val = 32'hDEADBEEF;
      #1;
      n_checks++; if (commit_valid !== 1'b0 || rob_out.busy[0] !== 1'b1) begin
         n_errors++; $display("FAIL no_forward got cv=%b busy0=%b exp 0 1", commit_valid, rob_out.busy[0]); end
      step();
      cdb_valid = 1'b0;
      #1;
      n_checks++; if (rob_out.busy[0] !== 1'b0 || rob_out.vals[0] !== 32'hDEADBEEF) begin
         n_errors++; $display("FAIL single_status got busy0=%b val0=%h exp 0 deadbeef", rob_out.busy[0], rob_out.vals[0]); end
      n_checks++; if (commit_valid !== 1'b1 || commit_rd !== 5'd5 || commit_tag !== tag_t'(1) || commit_val !== 32'hDEADBEEF || commit_op !== OP_REG) begin
         n_errors++; $display("FAIL single_commit got cv=%b rd=%0d tag=%0d val=%h exp 1 5 1 deadbeef", commit_valid, commit_rd, commit_tag, commit_val); end
      step();
      n_checks++; if (commit_valid !== 1'b0 || rob_out.busy !== '1 || rob_out.vals !== '0 || rob_out.tag !== tag_t'(2)) begin
         n_errors++; $display("FAIL single_empty got cv=%b busy=%b tag=%0d exp 0 all1 2", commit_valid, rob_out.busy, rob_out.tag); end
   endtask

   task automatic test_order();
      do_reset();
      alloc_valid = 1'b1; alloc_op = OP_REG; alloc_rd = 5'd1;
      step();
      alloc_rd = 5'd2;
      step();
      alloc_valid = 1'b0;
      cdb_valid = 1'b1; cdb_tag = tag_t'(2); cdb_val = 32'hAAAA0002;
      step();
      cdb_tag = tag_t'(1); cdb_val = 32'hBBBB0001;
      #1;
      n_checks++; if (commit_valid !== 1'b0 || rob_out.busy[1] !== 1'b0) begin
         n_errors++; $display("FAIL order_wait got cv=%b busy1=%b exp 0 0", commit_valid, rob_out.busy[1]); end
      step();
      cdb_valid = 1'b0;
      #1;
      n_checks++; if (commit_valid !== 1'b1 || commit_tag !== tag_t'(1) || commit_val !== 32'hBBBB0001) begin
         n_errors++; $display("FAIL order_first got cv=%b tag=%0d val=%h exp 1 1 bbbb0001", commit_valid, commit_tag, commit_val); end
      step();
      n_checks++; if (commit_valid !== 1'b1 || commit_tag !== tag_t'(2) || commit_val !== 32'hAAAA0002 || commit_rd !== 5'd2) begin
         n_errors++; $display("FAIL order_second got cv=%b tag=%0d val=%h exp 1 2 aaaa0002", commit_valid, commit_tag, commit_val); end
      step();
      n_checks++; if (commit_valid !== 1'b0) begin n_errors++; $display("FAIL order_empty got cv=%b exp 0", commit_valid); end
   endtask

   task automatic test_store();
      do_reset();
      alloc_valid = 1'b1; alloc_op = OP_ST; alloc_rd = '0;
      step();
      alloc_valid = 1'b0;
      cdb_valid = 1'b1; cdb_tag = tag_t'(1); cdb_val = 32'h0;
      step();
      cdb_valid = 1'b0; st_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         n_checks++; if (commit_valid !== 1'b0) begin n_errors++; $display("FAIL store_hold%0d got cv=%b exp 0", i, commit_valid); end
         step();
      end
      st_ready = 1'b1;
      #1;
      n_checks++; if (commit_valid !== 1'b1 || commit_op !== OP_ST) begin
         n_errors++; $display("FAIL store_commit got cv=%b op=%0d exp 1 %0d", commit_valid, commit_op, OP_ST); end
      step();
      n_checks++; if (commit_valid !== 1'b0) begin n_errors++; $display("FAIL store_once got cv=%b exp 0", commit_valid); end
   endtask

   task automatic test_flush();
      do_reset();
      alloc_valid = 1'b1; alloc_op = OP_BR;
      step();
      alloc_op = OP_REG; alloc_rd = 5'd3;
      step();
      alloc_valid = 1'b0;
      cdb_valid = 1'b1; cdb_tag = tag_t'(1); cdb_val = 32'h400; cdb_mispredict = 1'b1;
      step();
      // Alloc and CDB presented during the flush cycle must be dropped.
      alloc_valid = 1'b1; cdb_tag = tag_t'(2); cdb_val = 32'h55; cdb_mispredict = 1'b0;
      #1;
      n_checks++; if (flush !== 1'b1 || flush_pc !== 32'h400 || commit_valid !== 1'b1) begin
         n_errors++; $display("FAIL flush_assert got fl=%b pc=%h cv=%b exp 1 400 1", flush, flush_pc, commit_valid); end
      step();
      alloc_valid = 1'b0; cdb_valid = 1'b0;
      #1;
      n_checks++; if (flush !== 1'b0 || rob_out.tag !== tag_t'(1) || rob_out.busy !== '1 || commit_valid !== 1'b0 || rob_out.vals !== '0) begin
         n_errors++; $display("FAIL flush_clear got fl=%b tag=%0d busy=%b cv=%b exp 0 1 all1 0", flush, rob_out.tag, rob_out.busy, commit_valid); end
   endtask

   task automatic test_wrap();
      do_reset();
      alloc_valid = 1'b1; alloc_op = OP_REG;
      for (int i = 1; i <= int'(D); i++) begin
         alloc_rd = 5'(i);
         step();
      end
      alloc_valid = 1'b0;
      cdb_valid = 1'b1; cdb_tag = tag_t'(1); cdb_val = 32'h11;
      step();
      cdb_valid = 1'b0; alloc_valid = 1'b1; alloc_rd = 5'd20;
      #1;
      n_checks++; if (rob_out.tag !== tag_t'(0) || commit_valid !== 1'b1) begin
         n_errors++; $display("FAIL wrap_full got tag=%0d cv=%b exp 0 1", rob_out.tag, commit_valid); end
      step();
      n_checks++; if (rob_out.tag !== tag_t'(1) || commit_valid !== 1'b0) begin
         n_errors++; $display("FAIL wrap_tag got tag=%0d cv=%b exp 1 0", rob_out.tag, commit_valid); end
      step();
      alloc_valid = 1'b0;
      #1;
      n_checks++; if (rob_out.tag !== tag_t'(0) || commit_tag !== tag_t'(2) || rob_out.busy !== '1) begin
         n_errors++; $display("FAIL wrap_alloc got tag=%0d head=%0d busy=%b exp 0 2 all1", rob_out.tag, commit_tag, rob_out.busy); end
      cdb_valid = 1'b1; cdb_tag = tag_t'(1); cdb_val = 32'h77;
      step();
      cdb_valid = 1'b0;
      #1;
      n_checks++; if (rob_out.busy[0] !== 1'b0 || rob_out.vals[0] !== 32'h77 || commit_valid !== 1'b0) begin
         n_errors++; $display("FAIL wrap_entry got busy0=%b val0=%h cv=%b exp 0 77 0", rob_out.busy[0], rob_out.vals[0], commit_valid); end
   endtask

   task automatic test_random();
      m_ent_t        q[$];
      int            next_tag;
      int            pend[$];
      logic [D-1:0]  e_busy;
      rv32i_word [D-1:0] e_vals;
      bit            e_cv;
      bit            e_fl;
      bit            was_full;
      m_ent_t        ne;
      do_reset();
      next_tag = 1;
      for (int cyc = 0; cyc < 600; cyc++) begin
         alloc_valid    = ($urandom_range(0, 2) != 0);
         alloc_op       = op_type_t'(2'($urandom_range(0, 2)));
         alloc_rd       = 5'($urandom);
         cdb_valid      = ($urandom_range(0, 1) != 0);
         cdb_val        = $urandom;
         cdb_mispredict = ($urandom_range(0, 5) == 0);
         st_ready       = ($urandom_range(0, 3) != 0);
         pend.delete();
         foreach (q[k]) if (!q[k].done) pend.push_back(int'(q[k].tag));
         if (pend.size() > 0 && $urandom_range(0, 3) != 0)
            cdb_tag = tag_t'(pend[$urandom_range(0, pend.size() - 1)]);
         else
            cdb_tag = tag_t'($urandom_range(0, 7));
         #1;
         e_busy = '1;
         e_vals = '0;
         foreach (q[k]) if (q[k].done) begin
            e_busy[int'(q[k].tag) - 1] = 1'b0;
            e_vals[int'(q[k].tag) - 1] = q[k].val;
         end
         e_cv = (q.size() > 0) && q[0].done && (q[0].op != OP_ST || st_ready);
         e_fl = e_cv && q[0].op == OP_BR && q[0].mis;
         n_checks++; if (rob_out.tag !== ((q.size() == int'(D)) ? tag_t'(0) : tag_t'(next_tag))) begin
            n_errors++; $display("FAIL rnd_tag cyc %0d got %0d exp %0d", cyc, rob_out.tag, (q.size() == int'(D)) ? 0 : next_tag); end
         n_checks++; if (rob_out.busy !== e_busy || rob_out.vals !== e_vals) begin
            n_errors++; $display("FAIL rnd_status cyc %0d got busy=%b exp %b", cyc, rob_out.busy, e_busy); end
         n_checks++; if (commit_valid !== e_cv || flush !== e_fl) begin
            n_errors++; $display("FAIL rnd_commit cyc %0d got cv=%b fl=%b exp %b %b", cyc, commit_valid, flush, e_cv, e_fl); end
         if (e_cv) begin
            n_checks++; if (commit_tag !== q[0].tag || commit_op !== q[0].op || commit_rd !== q[0].rd || commit_val !== q[0].val) begin
               n_errors++; $display("FAIL rnd_head cyc %0d got tag=%0d rd=%0d val=%h exp %0d %0d %h", cyc, commit_tag, commit_rd, commit_val, q[0].tag, q[0].rd, q[0].val); end
         end
         if (e_fl) begin
            n_checks++; if (flush_pc !== q[0].val) begin
               n_errors++; $display("FAIL rnd_flush_pc cyc %0d got %h exp %h", cyc, flush_pc, q[0].val); end
         end
         // Advance the model by what the coming edge should do.
         if (e_fl) begin
            q.delete();
            next_tag = 1;
         end else begin
            if (cdb_valid) foreach (q[k]) if (q[k].tag == cdb_tag && !q[k].done) begin
               q[k].done = 1'b1; q[k].val = cdb_val; q[k].mis = cdb_mispredict;
            end
            was_full = (q.size() == int'(D));
            if (e_cv) void'(q.pop_front());
            if (alloc_valid && !was_full) begin
               ne.tag = tag_t'(next_tag); ne.op = alloc_op; ne.rd = alloc_rd;
               ne.done = 1'b0; ne.val = '0; ne.mis = 1'b0;
               q.push_back(ne);
               next_tag = (next_tag % int'(D)) + 1;
            end
         end
         step();
      end
      idle_inputs();
   endtask

   initial begin
      rst = 1'b1;
      idle_inputs();
      test_reset();
      test_fill();
      test_single();
      test_order();
      test_store();
      test_flush();
      test_wrap();
      test_random();
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/rob.md
ROB -- requirements
Module: rob

Interface
REQ-001 SHALL have parameter ROB_DEPTH, default 6 (from ooo_types), meaning number of reorder-buffer entries.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port alloc_valid  input  1  dispatch requests an entry this cycle.
REQ-005 SHALL have port alloc_op  input  op_type_t  REG/ST/BR type of dispatched instruction.
REQ-006 SHALL have port alloc_rd  input  5  destination register (REG only).
REQ-007 SHALL have port cdb_valid  input  1  a functional unit broadcasts a result.
REQ-008 SHALL have port cdb_tag  input  tag_t  ROB tag of broadcast result (1..ROB_DEPTH).
REQ-009 SHALL have port cdb_val  input  rv32i_word  result value (REG) or target PC (BR).
REQ-010 SHALL have port cdb_mispredict  input  1  BR result was mispredicted.
REQ-011 SHALL have port st_ready  input  1  load/store unit can retire a store this cycle.
REQ-012 SHALL have port rob_out  output  rob_out_t  free tag, per-entry busy and value to dispatch/reservation stations.
REQ-013 SHALL have ports commit_valid (1), commit_op (op_type_t), commit_rd (5), commit_val (rv32i_word), commit_tag (tag_t)  output  head-entry retirement.
REQ-014 SHALL have ports flush (1), flush_pc (rv32i_word)  output  pipeline flush request and redirect target.

Function
REQ-015 SHALL hold entries in a circular buffer with head, tail (0..ROB_DEPTH-1, wrap ROB_DEPTH-1 -> 0) and count (0..ROB_DEPTH); tag of index i is i+1.
REQ-016 SHALL drive rob_out.tag combinationally = tail+1 when count < ROB_DEPTH, else 0 (full).
REQ-017 SHALL allocate on an edge when alloc_valid and rob_out.tag != 0: entry[tail] valid=1, done=0, op/rd latched, val=0; tail advances; alloc with tag 0 ignored.
REQ-018 SHALL, on cdb_valid with cdb_tag in 1..ROB_DEPTH addressing a valid, not-done entry, set done=1, store cdb_val and cdb_mispredict; any other cdb_tag (0, >ROB_DEPTH, invalid or done entry) ignored.
REQ-019 SHALL drive rob_out.busy[i]=0 only when entry i is valid and done, else 1; rob_out.vals[i]=stored value.
REQ-020 SHALL assert commit_valid combinationally when head entry is valid and done, and additionally st_ready=1 if op is ST; commit_* reflect head entry, commit_tag=head+1.
REQ-021 SHALL, on an edge with commit_valid, clear head entry, advance head, decrement count.
REQ-022 SHALL assert flush with flush_pc=head val when commit_valid and head op is BR with stored mispredict=1; same edge clears all entries, head=tail=count=0, and ignores alloc and CDB that cycle.
REQ-023 SHALL handle simultaneous alloc and commit (no flush): count unchanged, both pointers advance; full status uses registered count, so no alloc when full even if committing.
REQ-024 SHALL forward nothing combinationally from CDB to rob_out/commit: CDB result visible one cycle later; latency dispatch->earliest commit = 2 edges.
REQ-025 SHALL keep commit_valid=0 and flush=0 when count=0.

Reset
REQ-026 SHALL, on rst=0 asynchronously, clear all entries (valid=0, done=0, val=0), head=tail=count=0.
REQ-027 SHALL present after reset: rob_out.tag=1, busy all 1, vals all 0, commit_valid=0, flush=0, flush_pc=0; reset mid-operation discards all in-flight entries.

Verification
REQ-028 SHALL pass: 6 allocs REG rd=1..6 -> tags 1..6 returned, then rob_out.tag=0; 7th alloc ignored.
REQ-029 SHALL pass: alloc tag1 rd=5, CDB tag1 val=0xDEADBEEF -> next cycle busy[0]=0, vals[0]=0xDEADBEEF, commit_valid=1, commit_rd=5; following cycle count=0.
REQ-030 SHALL pass: tags 1,2 allocated, CDB tag2 then tag1 -> commits strictly tag1 then tag2.
REQ-031 SHALL pass: ST at head done with st_ready=0 for 3 cycles -> commit_valid=0 held; st_ready=1 -> commits one cycle.
REQ-032 SHALL pass: BR tag1, REG tag2, CDB tag1 mispredict val=0x400 -> flush=1, flush_pc=0x400 at commit; next cycle count=0, rob_out.tag=1.
REQ-033 SHALL pass: fill to full, commit head while alloc_valid=1 -> no alloc that edge; next cycle tag=old head+1 (wrapped) and alloc accepted.
